// File: rtl/axi_stream_insert_header_pkg.sv
// rtl/axi_stream_insert_header_pkg.sv - shared types and byte-count helpers for the header inserter
package axi_stream_insert_header_pkg;

    localparam int BYTES = 4;

    typedef enum logic [1:0] {IDLE, DATA, TAIL} state_t;

    // Valid bytes of a final beat: contiguous ones counted down from keep[3].
    function automatic logic [2:0] leading_ones(input logic [3:0] keep);
        logic [2:0] n;
        logic       run;
        n   = 3'd0;
        run = 1'b1;
        for (int i = BYTES - 1; i >= 0; i--) begin
            run = run & keep[i];
            n   = n + {2'b00, run};
        end
        return n;
    endfunction

    function automatic logic [2:0] trailing_ones(input logic [3:0] keep);
        logic [2:0] n;
        logic       run;
        n   = 3'd0;
        run = 1'b1;
        for (int i = 0; i < BYTES; i++) begin
            run = run & keep[i];
            n   = n + {2'b00, run};
        end
        return n;
    endfunction

    function automatic logic [3:0] keep_from_count(input logic [2:0] cnt);
        case (cnt)
            3'd0:    return 4'b0000;
            3'd1:    return 4'b1000;
            3'd2:    return 4'b1100;
            3'd3:    return 4'b1110;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/axi_stream_insert_header_packer.sv
// rtl/axi_stream_insert_header_packer.sv - merges MSB-aligned carry bytes with one beat into an output word plus new carry
module axis_byte_packer
    import axi_stream_insert_header_pkg::*;
(
    input  logic [31:0] carry_data,
    input  logic [2:0]  carry_cnt,
    input  logic [31:0] beat_data,
    input  logic [2:0]  beat_cnt,
    output logic [31:0] out_data,
    output logic [3:0]  out_keep,
    output logic [31:0] next_carry_data,
    output logic [2:0]  next_carry_cnt,
    output logic        overflow
);

    logic [31:0] beat_mask;
    logic [3:0]  beat_keep;
    logic [63:0] combined;
    logic [3:0]  total;
    logic [3:0]  remainder;

    always_comb begin
        beat_keep = keep_from_count(beat_cnt);
        beat_mask = '0;
        for (int i = 0; i < BYTES; i++) begin
            beat_mask[i*8 +: 8] = {8{beat_keep[i]}};
        end
        // Beat bytes slide in directly behind the carry bytes; unused bytes stay zero.
        combined        = {carry_data, 32'h0} | ({beat_data & beat_mask, 32'h0} >> {carry_cnt, 3'b000});
        total           = {1'b0, carry_cnt} + {1'b0, beat_cnt};
        remainder       = total - 4'd4;
        overflow        = (total > 4'd4);
        out_data        = combined[63:32];
        out_keep        = keep_from_count(overflow ? 3'd4 : total[2:0]);
        next_carry_data = overflow ? combined[31:0] : 32'h0;
        next_carry_cnt  = overflow ? remainder[2:0] : 3'd0;
    end

endmodule

// File: rtl/axi_stream_insert_header.sv
// rtl/axi_stream_insert_header.sv - prepends a per-packet header to an AXI-Stream packet, re-packed MSB-first
module axi_stream_insert_header
    import axi_stream_insert_header_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        valid_in,
    input  logic [31:0] data_in,
    input  logic [3:0]  keep_in,
    input  logic        last_in,
    output logic        ready_in,
    input  logic        valid_insert,
    input  logic [31:0] data_insert,
    input  logic [3:0]  keep_insert,
    input  logic [1:0]  byte_insert_cnt,
    output logic        ready_insert,
    output logic        valid_out,
    output logic [31:0] data_out,
    output logic [3:0]  keep_out,
    output logic        last_out,
    input  logic        ready_out
);

    state_t      state;
    logic [31:0] carry_data;
    logic [2:0]  carry_cnt;
    logic        out_free;
    logic        accept_in;
    logic [2:0]  beat_cnt;
    logic [2:0]  hdr_cnt;
    logic [31:0] pk_data;
    logic [3:0]  pk_keep;
    logic [31:0] pk_carry_data;
    logic [2:0]  pk_carry_cnt;
    logic        pk_overflow;
    logic        unused_byte_insert_cnt;

    assign unused_byte_insert_cnt = ^byte_insert_cnt;

    assign out_free     = !valid_out || ready_out;
    assign ready_insert = (state == IDLE);
    assign ready_in     = (state == DATA) && out_free;
    assign accept_in    = valid_in && ready_in;
    assign beat_cnt     = last_in ? leading_ones(keep_in) : 3'd4;
    assign hdr_cnt      = trailing_ones(keep_insert);

    axis_byte_packer u_packer (
        .carry_data      (carry_data),
        .carry_cnt       (carry_cnt),
        .beat_data       (data_in),
        .beat_cnt        (beat_cnt),
        .out_data        (pk_data),
        .out_keep        (pk_keep),
        .next_carry_data (pk_carry_data),
        .next_carry_cnt  (pk_carry_cnt),
        .overflow        (pk_overflow)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            carry_data <= '0;
            carry_cnt  <= '0;
            valid_out  <= 1'b0;
            data_out   <= '0;
            keep_out   <= '0;
            last_out   <= 1'b0;
        end else begin
            if (out_free) begin
                valid_out <= 1'b0;
                last_out  <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (valid_insert) begin
                        // Header's low bytes become the MSB-aligned carry.
                        carry_data <= data_insert << {3'd4 - hdr_cnt, 3'b000};
                        carry_cnt  <= hdr_cnt;
                        state      <= DATA;
                    end
                end
                DATA: begin
                    if (accept_in) begin
                        valid_out  <= 1'b1;
                        data_out   <= pk_data;
                        keep_out   <= pk_keep;
                        carry_data <= pk_carry_data;
                        carry_cnt  <= pk_carry_cnt;
                        if (last_in && !pk_overflow) begin
                            last_out <= 1'b1;
                            state    <= IDLE;
                        end else if (last_in) begin
                            state <= TAIL;
                        end
                    end
                end
                TAIL: begin
                    if (out_free) begin
                        valid_out  <= 1'b1;
                        data_out   <= carry_data;
                        keep_out   <= keep_from_count(carry_cnt);
                        last_out   <= 1'b1;
                        carry_data <= '0;
                        carry_cnt  <= '0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_stream_insert_header.sv
// tb/tb_axi_stream_insert_header.sv - scoreboard bench for axi_stream_insert_header
module tb_axi_stream_insert_header;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        valid_in = 1'b0;
    logic [31:0] data_in = '0;
    logic [3:0]  keep_in = '0;
    logic        last_in = 1'b0;
    logic        ready_in;
    logic        valid_insert = 1'b0;
    logic [31:0] data_insert = '0;
    logic [3:0]  keep_insert = '0;
    logic [1:0]  byte_insert_cnt = '0;
    logic        ready_insert;
    logic        valid_out;
    logic [31:0] data_out;
    logic [3:0]  keep_out;
    logic        last_out;
    logic        ready_out = 1'b1;

    axi_stream_insert_header dut (
        .clk             (clk),
        .rstn            (rstn),
        .valid_in        (valid_in),
        .data_in         (data_in),
        .keep_in         (keep_in),
        .last_in         (last_in),
        .ready_in        (ready_in),
        .valid_insert    (valid_insert),
        .data_insert     (data_insert),
        .keep_insert     (keep_insert),
        .byte_insert_cnt (byte_insert_cnt),
        .ready_insert    (ready_insert),
        .valid_out       (valid_out),
        .data_out        (data_out),
        .keep_out        (keep_out),
        .last_out        (last_out),
        .ready_out       (ready_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } beat_t;

    beat_t       exp_q[$];
    beat_t       mon_e;
    int          checks = 0;
    int          failures = 0;
    int          n_last = 0;
    int          n_hdr = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    logic [3:0]  prev_keep = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rstn) begin
            if (prev_stall) begin
                check("hold_data", data_out, prev_data);
                check("hold_keep", keep_out, prev_keep);
            end
            prev_stall = valid_out && !ready_out;
            prev_data  = data_out;
            prev_keep  = keep_out;
            if (valid_insert && ready_insert) n_hdr++;
            if (valid_out && ready_out) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat: got data %h keep %b last %b expected no beat", data_out, keep_out, last_out);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("out_data", data_out, mon_e.data);
                    check("out_keep", keep_out, mon_e.keep);
                    check("out_last", last_out, mon_e.last);
                end
                if (last_out) n_last++;
            end
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic expect_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        beat_t b;
        b.data = d;
        b.keep = k;
        b.last = l;
        exp_q.push_back(b);
    endtask

    task automatic send_header(input logic [31:0] d, input logic [3:0] k);
        int n;
        data_insert     = d;
        keep_insert     = k;
        byte_insert_cnt = 2'($countones(k) - 1);
        valid_insert    = 1'b1;
        n = 0;
        @(negedge clk);
        while (!ready_insert && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("header_timeout", 64'd1, 64'd0);
        @(posedge clk);
        #1;
        valid_insert = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        int n;
        data_in  = d;
        keep_in  = k;
        last_in  = l;
        valid_in = 1'b1;
        n = 0;
        @(negedge clk);
        while (!ready_in && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("beat_timeout", 64'd1, 64'd0);
        @(posedge clk);
        #1;
        valid_in = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic packet_one(input bit stall);
        expect_beat(32'hCDEF8800, 4'b1111, 1'b0);
        expect_beat(32'h01020304, 4'b1111, 1'b0);
        expect_beat(32'h05060708, 4'b1111, 1'b0);
        expect_beat(32'h090A0B0C, 4'b1111, 1'b0);
        expect_beat(32'h0D0E0F10, 4'b1111, 1'b0);
        expect_beat(32'h11121314, 4'b1111, 1'b0);
        expect_beat(32'h15161718, 4'b1111, 1'b0);
        expect_beat(32'h19000000, 4'b1000, 1'b1);
        send_header(32'hABCDEF88, 4'b0111);
        send_beat(32'h00010203, 4'b1111, 1'b0);
        send_beat(32'h04050607, 4'b1111, 1'b0);
        send_beat(32'h08090A0B, 4'b1111, 1'b0);
        send_beat(32'h0C0D0E0F, 4'b1111, 1'b0);
        send_beat(32'h10111213, 4'b1111, 1'b0);
        send_beat(32'h14151617, 4'b1111, 1'b0);
        if (stall) begin
            ready_out = 1'b0;
            fork
                begin
                    repeat (5) begin
                        @(negedge clk);
                        check("stall_ready_in", ready_in, 0);
                    end
                    @(posedge clk);
                    #1;
                    ready_out = 1'b1;
                end
            join_none
        end
        send_beat(32'h1819A5A5, 4'b1100, 1'b1);
        drain();
    endtask

    task automatic packet_short();
        expect_beat(32'h99112233, 4'b1111, 1'b1);
        send_header(32'h12345699, 4'b0001);
        send_beat(32'h112233EE, 4'b1110, 1'b1);
        drain();
    endtask

    initial begin
        int hdr0;
        int last0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid_out", valid_out, 0);
        check("rst_data_out", data_out, 0);
        check("rst_keep_out", keep_out, 0);
        check("rst_last_out", last_out, 0);
        check("rst_ready_in", ready_in, 0);
        check("rst_ready_insert", ready_insert, 1);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        packet_one(1'b0);
        packet_one(1'b1);

        expect_beat(32'hAABBCCDD, 4'b1111, 1'b0);
        expect_beat(32'h01020304, 4'b1111, 1'b0);
        expect_beat(32'h05060000, 4'b1100, 1'b1);
        send_header(32'hAABBCCDD, 4'b1111);
        send_beat(32'h01020304, 4'b1111, 1'b0);
        send_beat(32'h05067777, 4'b1100, 1'b1);
        drain();

        packet_short();

        hdr0  = n_hdr;
        last0 = n_last;
        for (int p = 0; p < 2; p++) begin
            expect_beat(32'hBE01A0A1, 4'b1111, 1'b0);
            expect_beat(32'hA2A3B0B1, 4'b1111, 1'b1);
        end
        data_insert     = 32'hDEADBE01;
        keep_insert     = 4'b0011;
        byte_insert_cnt = 2'd1;
        valid_insert    = 1'b1;
        send_beat(32'hA0A1A2A3, 4'b1111, 1'b0);
        send_beat(32'hB0B1CCCC, 4'b1100, 1'b1);
        send_beat(32'hA0A1A2A3, 4'b1111, 1'b0);
        valid_insert = 1'b0;
        send_beat(32'hB0B1CCCC, 4'b1100, 1'b1);
        drain();
        check("b2b_headers", n_hdr - hdr0, 2);
        check("b2b_lasts", n_last - last0, 2);

        expect_beat(32'hCDEF8800, 4'b1111, 1'b0);
        send_header(32'hABCDEF88, 4'b0111);
        send_beat(32'h00010203, 4'b1111, 1'b0);
        @(negedge clk);
        #1;
        rstn = 1'b0;
        #1;
        check("midrst_valid_out", valid_out, 0);
        check("midrst_keep_out", keep_out, 0);
        check("midrst_ready_insert", ready_insert, 1);
        check("midrst_ready_in", ready_in, 0);
        check("midrst_queue", exp_q.size(), 0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        packet_short();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
